video_timing_gen: RTL

Synthetic video source for the Sobel pipeline. It generates a raster-timed 8-bit grayscale stream with `hsync`, `vsync` and `de`, plus a selectable test pattern. This is the transmit end of the pixel/sync interface that the line buffer and filter stages consume. It sits at the head of the pipeline in simulation and on hardware bring-up, standing in for the camera or HDMI receiver, and it only ever hands over whole frames.

---
 rtl/video_timing_gen.sv | 138 +++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator with selectable 8-bit test patterns.
// Runs whole frames only; every output is registered one clock behind the counters.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned H_FP       = 88,
  parameter int unsigned H_SYNC     = 44,
  parameter int unsigned H_BP       = 148,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned V_FP       = 4,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 36,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter logic [7:0]  FLAT_VALUE = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic [7:0] pixel_out,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W       = $clog2(H_TOTAL);
  localparam int unsigned V_W       = $clog2(V_TOTAL);
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_next;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic [1:0]     pat;
  logic           h_last, frame_last;
  logic [31:0]    x, y;
  logic [7:0]     pixel_c;
  logic           hsync_c, vsync_c, de_c, frame_start_c, busy_c;

  assign h_last     = (h_cnt == H_LAST);
  assign frame_last = h_last && (v_cnt == V_LAST);
  assign x          = 32'(h_cnt);
  assign y          = 32'(v_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Frames only start from IDLE and only stop at the last pixel of a frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (frame_last && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state == RUN) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // Pattern shadow is captured whenever the raster is about to enter (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat <= 2'd0;
    end else if ((state == IDLE && enable) || (state == RUN && frame_last && enable)) begin
      pat <= pattern_sel;
    end
  end

  always_comb begin
    pixel_c       = 8'd0;
    hsync_c       = ~HS_POL;
    vsync_c       = ~VS_POL;
    de_c          = 1'b0;
    frame_start_c = 1'b0;
    busy_c        = 1'b0;
    if (state == RUN) begin
      busy_c        = 1'b1;
      de_c          = (x < H_ACTIVE) && (y < V_ACTIVE);
      frame_start_c = (x == 32'd0) && (y == 32'd0);
      if (x >= HS_START && x < HS_END) hsync_c = HS_POL;
      if (y >= VS_START && y < VS_END) vsync_c = VS_POL;
      if (de_c) begin
        case (pat)
          2'd0:    pixel_c = x[7:0];
          2'd1:    pixel_c = y[7:0];
          2'd2:    pixel_c = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
          default: pixel_c = FLAT_VALUE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out   <= 8'd0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pixel_out   <= pixel_c;
      hsync       <= hsync_c;
      vsync       <= vsync_c;
      de          <= de_c;
      frame_start <= frame_start_c;
      busy        <= busy_c;
    end
  end

endmodule
